// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM states, PPROT encodings, data-width check.
// Imported by apb_master_bridge; holds no logic of its own.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    // PPROT bits: [0]=privileged, [1]=non-secure, [2]=instruction
    localparam logic [2:0] PPROT_NORMAL_SECURE_DATA = 3'b000;
    localparam logic [2:0] PPROT_PRIV_SECURE_DATA   = 3'b001;
    localparam logic [2:0] PPROT_NORMAL_NSEC_DATA   = 3'b010;
    localparam logic [2:0] PPROT_NORMAL_SECURE_INSN = 3'b100;

    // APB data buses are 8, 16 or 32 bits wide
    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32);
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3/APB4 requester: cmd valid/ready in, APB out,
// response valid/ready back; PREADY waits, PSLVERR, access timeout.
// Ports: PCLK, PRESET (async, active high); cmd_* command stream;
// rsp_* response stream; PADDR..PSTRB, PREADY, PRDATA, PSLVERR APB bus.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [2:0]              PPROT,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1
                      : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);

    if (!dw_legal(DATA_WIDTH)) begin : g_bad_dw
        $error("apb_master_bridge: DATA_WIDTH must be 8, 16 or 32");
    end

    apb_state_e    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          ready_en;
    logic          take;
    logic          to_hit;

    // Saturating increment: the wait counter never wraps
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

    // ready_en keeps cmd_ready low while reset is held and for the
    // partial cycle after release
    assign cmd_ready = ready_en &&
        ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
    assign take = cmd_valid && cmd_ready;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ready_en    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PPROT       <= PPROT_NORMAL_SECURE_DATA;
            PSTRB       <= '0;
        end else begin
            ready_en <= 1'b1;
            unique case (state)
                ST_IDLE: ;
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (to_hit) begin
                            PSELx       <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A handshake (from IDLE or a retiring RESP) overrides the
            // case above and launches the next transfer
            if (take) begin
                PADDR   <= cmd_addr;
                PWRITE  <= cmd_write;
                PWDATA  <= cmd_wdata;
                PPROT   <= cmd_prot;
                PSTRB   <= cmd_write ? cmd_strb : SW'(0);
                PSELx   <= 1'b1;
                PENABLE <= 1'b0;
                cnt     <= '0;
                state   <= ST_SETUP;
            end
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3/APB4 requester that turns a valid/ready command stream into APB transfers and returns a response stream.
- Drives the PADDR/PSELx/PENABLE/PWRITE/PWDATA/PPROT/PSTRB bus consumed by the team's APB slave cores, such as the register/UART slave.
- Handles PREADY wait states, PSLVERR, and a programmable access timeout, so a hung slave can never lock the requester.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data; must be 8, 16 or 32; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, number of PREADY-low ACCESS cycles before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PPROT  out  3  APB protection.
- PSTRB  out  DATA_WIDTH/8  APB strobes.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESET high, any time): state=IDLE, timeout counter=0. All outputs are 0, including cmd_ready, which rises in the first cycle after reset release.
- A reset during SETUP or ACCESS drops PSELx and PENABLE immediately (asynchronously); no response is produced for that transfer.
- States are IDLE, SETUP, ACCESS and RESP. All APB outputs and response outputs are registered.
- cmd_ready = (state==IDLE) || (state==RESP && rsp_ready). The handshake is cmd_valid && cmd_ready.
- On a command handshake:
  - the command is latched into PADDR/PWRITE/PWDATA/PPROT/PSTRB;
  - PSTRB is forced to 0 when cmd_write=0;
  - PSELx=1 and PENABLE=0 next cycle; state=SETUP.
- SETUP lasts exactly 1 cycle; then PENABLE=1 and state=ACCESS. PREADY is ignored in SETUP.
- ACCESS:
  - Sample PREADY every cycle.
  - PREADY=1 completes the transfer. Next cycle: PSELx=0, PENABLE=0, rsp_valid=1. rsp_rdata=PRDATA for reads and 0 for writes. rsp_err=PSLVERR, rsp_timeout=0. state=RESP.
  - PREADY=0: increment the timeout counter.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: next cycle PSELx=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; state=RESP.
  - Counter behaviour: it clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1, and it saturates; it never wraps.
- RESP:
  - rsp_* are held stable until rsp_valid && rsp_ready.
  - If rsp_ready=1 and cmd_valid=1 in the same cycle, the response retires and the new command goes straight to SETUP (back-to-back).
  - If rsp_ready=1 and cmd_valid=0, go to IDLE and clear rsp_valid.
- Bus-hold rules:
  - PADDR, PWRITE, PWDATA, PPROT and PSTRB are stable from SETUP through the completing ACCESS cycle.
  - They hold their last value while idle.
  - PSELx=0 implies PENABLE=0.
- Latency, zero-wait slave: command handshake at cycle N → SETUP at N+1 → ACCESS at N+2 → rsp_valid at N+3. Sustained throughput is 1 transfer per 3 cycles with rsp_ready held high.
- Input changes to cmd_* while cmd_ready=0 have no effect.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - PPROT encoding constants (PPROT_NORMAL_SECURE_DATA = 3'b000);
  - a DATA_WIDTH legality check helper.
- No sub-module is needed. The timeout counter stays inline.

Test Plan:
- Zero-wait write: cmd addr=0x43C0_0000, wdata=0xDEAD_BEEF, strb=0xF, PREADY tied 1.
  → PSELx high for 2 cycles, PENABLE in the 2nd, PWDATA=0xDEAD_BEEF, PSTRB=0xF.
  → rsp_valid 3 cycles after the handshake with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: addr=0x43C0_000C; PREADY low for 2 ACCESS cycles, then high with PRDATA=0x1234_5678.
  → PSTRB=0 throughout, PADDR stable.
  → rsp_rdata=0x1234_5678, rsp_valid at handshake+5.
- Slave error: write with PREADY=1, PSLVERR=1 → rsp_err=1, rsp_timeout=0.
- Timeout with TIMEOUT_CYCLES=8 and PREADY stuck 0:
  → exactly 8 ACCESS cycles, then PSELx/PENABLE drop.
  → rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  → a following zero-wait read completes normally.
- Back-to-back and backpressure:
  - 4 queued commands with rsp_ready=1 → new SETUP every 3 cycles.
  - rsp_ready held 0 for 5 cycles → rsp_* unchanged, cmd_ready=0, no APB activity.
- Reset mid-ACCESS: assert PRESET during a wait-stated read.
  → PSELx/PENABLE/rsp_valid go 0 immediately.
  → cmd_ready=1 one cycle after release, and the next command runs cleanly.
